// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: M-extension funct3 codes, mul/div FSM states and ALU op codes.
package rv32_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [4:0] MULDIV_LAST_ITER = 5'd31;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: done pulses 33 edges after the accepting edge (1 for div-by-zero/overflow).
// No backpressure; start is only looked at while idle, so the control unit must stall the PC while busy is high.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int DW = 2 * XLEN;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  muldiv_state_e state;
  muldiv_op_e    op_q;
  muldiv_op_e    op_in;
  logic          div_q;
  logic          neg_q;
  logic [4:0]    cnt;
  logic [DW-1:0] acc;
  logic [XLEN-1:0] opnd;

  logic            a_signed, b_signed, a_neg, b_neg, in_div, neg_in;
  logic            special, b_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  logic [XLEN:0]   mul_sum;
  logic [DW-1:0]   mul_nx, div_nx, acc_nx, prod;
  logic            div_ge;
  logic [XLEN-1:0] div_diff, div_sel, res_final;

  // Operand decode: magnitudes, result sign and the cases resolved without iterating.
  always_comb begin
    op_in    = muldiv_op_e'(op);
    in_div   = op[2];
    a_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
               (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed & A[XLEN-1];
    b_neg    = b_signed & B[XLEN-1];
    a_mag    = neg_if(A, a_neg);
    b_mag    = neg_if(B, b_neg);

    case (op_in)
      OP_DIV:            neg_in = a_neg ^ b_neg;
      OP_REM:            neg_in = a_neg;
      OP_DIVU, OP_REMU:  neg_in = 1'b0;
      default:           neg_in = a_neg ^ b_neg;
    endcase

    b_zero  = (B == '0);
    ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
              (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    special = in_div && (b_zero || ovf);

    // op[1] separates REM/REMU from DIV/DIVU
    if (b_zero)
      special_res = op[1] ? A : '1;
    else
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of either algorithm; the low half of acc holds multiplier / dividend bits.
  always_comb begin
    mul_sum  = {1'b0, acc[DW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx   = {mul_sum, acc[XLEN-1:1]};

    div_ge   = acc[DW-1:XLEN-1] >= {1'b0, opnd};
    div_diff = acc[DW-2:XLEN-1] - opnd;
    div_nx   = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[DW-2:0], 1'b0};

    acc_nx   = div_q ? div_nx : mul_nx;

    prod     = neg_q ? (~acc_nx + DW'(1)) : acc_nx;
    div_sel  = ((op_q == OP_REM) || (op_q == OP_REMU)) ? acc_nx[DW-1:XLEN] : acc_nx[XLEN-1:0];

    if (div_q)
      res_final = neg_if(div_sel, neg_q);
    else if (op_q == OP_MUL)
      res_final = prod[XLEN-1:0];
    else
      res_final = prod[DW-1:XLEN];
  end

  // done/busy are registered off the state, so they trail the DONE state by one edge:
  // the done=1 cycle is already IDLE and can accept the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
      op_q   <= OP_MUL;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_in;
            div_q <= in_div;
            neg_q <= neg_in;
            cnt   <= '0;
            busy  <= 1'b1;
            if (special) begin
              acc    <= '0;
              opnd   <= '0;
              Result <= special_res;
              state  <= DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
              opnd  <= in_div ? b_mag : a_mag;
              state <= CALC;
            end
          end
        end

        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 5'd1;
          if (cnt == MULDIV_LAST_ITER) begin
            Result <= res_final;
            state  <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
